// File: rtl/matrix_gen_batch.sv
// Generates batches of random m x n matrices, streams each element as decimal text over UART
// and writes it to memory; handshakes slot allocation and commit with the matrix directory.
`timescale 1ns/1ps
`ifndef ELEMENT_WIDTH
`define ELEMENT_WIDTH 8
`endif
`ifndef BRAM_ADDR_WIDTH
`define BRAM_ADDR_WIDTH 8
`endif
`ifndef ERR_NONE
`define ERR_NONE 4'd0
`endif
`ifndef ERR_DIM_RANGE
`define ERR_DIM_RANGE 4'd1
`endif
`ifndef ERR_ALLOC_FAIL
`define ERR_ALLOC_FAIL 4'd2
`endif

module matrix_gen_batch #(
  parameter int          ELEMENT_WIDTH = `ELEMENT_WIDTH,
  parameter int          ADDR_WIDTH    = `BRAM_ADDR_WIDTH,
  parameter int          MAX_BATCH     = 4,
  parameter logic [15:0] LFSR_SEED     = 16'hACE1
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     mode_active,
  input  logic [3:0]               config_max_dim,
  input  logic [ELEMENT_WIDTH-1:0] config_max_value,
  input  logic [7:0]               rx_data,
  input  logic                     rx_done,
  output logic                     clear_rx_buffer,
  output logic [7:0]               tx_data,
  output logic                     tx_start,
  input  logic                     tx_busy,
  output logic                     alloc_req,
  input  logic [3:0]               alloc_slot,
  input  logic [ADDR_WIDTH-1:0]    alloc_addr,
  input  logic                     alloc_valid,
  input  logic                     alloc_fail,
  output logic                     commit_req,
  output logic [3:0]               commit_slot,
  output logic [3:0]               commit_m,
  output logic [3:0]               commit_n,
  output logic [ADDR_WIDTH-1:0]    commit_addr,
  output logic                     mem_wr_en,
  output logic [ADDR_WIDTH-1:0]    mem_wr_addr,
  output logic [ELEMENT_WIDTH-1:0] mem_wr_data,
  output logic [3:0]               error_code,
  output logic [3:0]               sub_state
);

  typedef enum logic [3:0] {
    IDLE = 4'd0, WAIT_M = 4'd1, WAIT_N = 4'd2, WAIT_K = 4'd3, ALLOC = 4'd4,
    DRAW = 4'd5, CONV = 4'd6, SEND_DIG = 4'd7, SEND_SEP = 4'd8, COMMIT = 4'd9,
    NEXT = 4'd10, DONE = 4'd11, ERROR = 4'd12
  } state_t;

  localparam logic [3:0] MAX_K = 4'(MAX_BATCH);

  state_t state, state_nxt;

  logic [15:0]           lfsr;
  logic [3:0]            m_q, n_q, k_q, done_cnt, row, col, slot_q, hund, tens;
  logic [ADDR_WIDTH-1:0] base_q;
  logic [6:0]            idx;
  logic [7:0]            rem;
  logic [1:0]            dig_sel;

  logic       rx_ok, is_digit, dim_ok, k_ok, cand_ok, tx_free, last_col;
  logic [3:0] digit;
  logic [7:0] cand, dig_byte, tx_byte;
  logic       clear_nxt, tx_nxt, we_nxt, commit_nxt, err_we;
  logic [3:0] err_val;

  // A byte whose clear is already in flight is still visible for one cycle; ignore it.
  assign rx_ok    = rx_done && !clear_rx_buffer;
  assign is_digit = (rx_data >= 8'h30) && (rx_data <= 8'h39);
  assign digit    = rx_data[3:0];
  assign dim_ok   = (digit != 4'd0) && (digit <= config_max_dim);
  assign k_ok     = (digit != 4'd0) && (digit <= MAX_K);
  assign cand     = 8'(lfsr[ELEMENT_WIDTH-1:0]);
  assign cand_ok  = cand <= 8'(config_max_value);
  assign tx_free  = !tx_busy && !tx_start;
  assign last_col = (col == n_q - 4'd1);
  assign dig_byte = 8'h30 + ((dig_sel == 2'd2) ? {4'd0, hund} :
                             (dig_sel == 2'd1) ? {4'd0, tens} : rem);
  assign tx_byte  = (state == SEND_DIG) ? dig_byte : (last_col ? 8'h0A : 8'h20);
  assign alloc_req = (state == ALLOC);
  assign sub_state = state;

  always_comb begin
    state_nxt  = state;
    clear_nxt  = 1'b0;
    tx_nxt     = 1'b0;
    we_nxt     = 1'b0;
    commit_nxt = 1'b0;
    err_we     = 1'b0;
    err_val    = error_code;
    case (state)
      IDLE: state_nxt = WAIT_M;
      WAIT_M, WAIT_N, WAIT_K: begin
        if (rx_ok) begin
          clear_nxt = 1'b1;
          if (is_digit) begin
            if ((state == WAIT_K) ? k_ok : dim_ok) begin
              state_nxt = (state == WAIT_M) ? WAIT_N : (state == WAIT_N) ? WAIT_K : ALLOC;
            end else begin
              err_we    = 1'b1;
              err_val   = `ERR_DIM_RANGE;
              state_nxt = ERROR;
            end
          end
        end
      end
      ALLOC: begin
        if (alloc_valid) begin
          state_nxt = DRAW;
        end else if (alloc_fail) begin
          err_we    = 1'b1;
          err_val   = `ERR_ALLOC_FAIL;
          state_nxt = ERROR;
        end
      end
      DRAW: begin
        if (cand_ok) begin
          we_nxt    = 1'b1;
          state_nxt = CONV;
        end
      end
      CONV: if (rem < 8'd10) state_nxt = SEND_DIG;
      SEND_DIG: begin
        if (tx_free) begin
          tx_nxt = 1'b1;
          if (dig_sel == 2'd0) state_nxt = SEND_SEP;
        end
      end
      SEND_SEP: begin
        if (tx_free) begin
          tx_nxt    = 1'b1;
          state_nxt = (last_col && row == m_q - 4'd1) ? COMMIT : DRAW;
        end
      end
      COMMIT: begin
        commit_nxt = 1'b1;
        state_nxt  = NEXT;
      end
      NEXT:  state_nxt = (done_cnt < k_q) ? ALLOC : DONE;
      DONE:  state_nxt = IDLE;
      ERROR: begin
        if (rx_ok) begin
          clear_nxt = 1'b1;
          err_we    = 1'b1;
          err_val   = `ERR_NONE;
          state_nxt = WAIT_M;
        end
      end
      default: state_nxt = IDLE;
    endcase
    // Disabling abandons any partial matrix; the last error stays visible.
    if (!mode_active) begin
      state_nxt  = IDLE;
      clear_nxt  = 1'b0;
      tx_nxt     = 1'b0;
      we_nxt     = 1'b0;
      commit_nxt = 1'b0;
      err_we     = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nxt;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      lfsr            <= LFSR_SEED;
      clear_rx_buffer <= 1'b0;
      tx_start        <= 1'b0;
      tx_data         <= 8'h00;
      mem_wr_en       <= 1'b0;
      mem_wr_addr     <= '0;
      mem_wr_data     <= '0;
      commit_req      <= 1'b0;
      commit_slot     <= 4'd0;
      commit_m        <= 4'd0;
      commit_n        <= 4'd0;
      commit_addr     <= '0;
      error_code      <= `ERR_NONE;
      m_q             <= 4'd0;
      n_q             <= 4'd0;
      k_q             <= 4'd0;
      done_cnt        <= 4'd0;
      row             <= 4'd0;
      col             <= 4'd0;
      slot_q          <= 4'd0;
      base_q          <= '0;
      idx             <= 7'd0;
      rem             <= 8'd0;
      hund            <= 4'd0;
      tens            <= 4'd0;
      dig_sel         <= 2'd0;
    end else begin
      clear_rx_buffer <= clear_nxt;
      tx_start        <= tx_nxt;
      mem_wr_en       <= we_nxt;
      commit_req      <= commit_nxt;
      if (mode_active) lfsr <= {1'b0, lfsr[15:1]} ^ (lfsr[0] ? 16'hB400 : 16'h0000);
      if (err_we) error_code <= err_val;
      if (state == WAIT_M && state_nxt == WAIT_N) m_q <= digit;
      if (state == WAIT_N && state_nxt == WAIT_K) n_q <= digit;
      if (state == WAIT_K && state_nxt == ALLOC) begin
        k_q      <= digit;
        done_cnt <= 4'd0;
      end
      if (state == ALLOC && state_nxt == DRAW) begin
        slot_q <= alloc_slot;
        base_q <= alloc_addr;
        idx    <= 7'd0;
        row    <= 4'd0;
        col    <= 4'd0;
      end
      if (we_nxt) begin
        mem_wr_addr <= base_q + ADDR_WIDTH'(idx);
        mem_wr_data <= cand[ELEMENT_WIDTH-1:0];
        idx         <= idx + 7'd1;
        rem         <= cand;
        hund        <= 4'd0;
        tens        <= 4'd0;
      end
      // One subtraction per cycle; the leading digit position is chosen once the remainder is < 10.
      if (state == CONV && mode_active) begin
        if (rem >= 8'd100) begin
          rem  <= rem - 8'd100;
          hund <= hund + 4'd1;
        end else if (rem >= 8'd10) begin
          rem  <= rem - 8'd10;
          tens <= tens + 4'd1;
        end else begin
          dig_sel <= (hund != 4'd0) ? 2'd2 : (tens != 4'd0) ? 2'd1 : 2'd0;
        end
      end
      if (tx_nxt) tx_data <= tx_byte;
      if (tx_nxt && state == SEND_DIG && dig_sel != 2'd0) dig_sel <= dig_sel - 2'd1;
      if (tx_nxt && state == SEND_SEP) begin
        if (last_col) begin
          col <= 4'd0;
          row <= row + 4'd1;
        end else begin
          col <= col + 4'd1;
        end
      end
      if (commit_nxt) begin
        commit_slot <= slot_q;
        commit_m    <= m_q;
        commit_n    <= n_q;
        commit_addr <= base_q;
        done_cnt    <= done_cnt + 4'd1;
      end
    end
  end

endmodule

// File: tb/tb_matrix_gen_batch.sv
// Bench for matrix_gen_batch: randomized commands, allocator/UART responders and a queue scoreboard.
`timescale 1ns/1ps
`ifndef ERR_NONE
`define ERR_NONE 4'd0
`endif
`ifndef ERR_DIM_RANGE
`define ERR_DIM_RANGE 4'd1
`endif
`ifndef ERR_ALLOC_FAIL
`define ERR_ALLOC_FAIL 4'd2
`endif

module tb_matrix_gen_batch;
  localparam int EW = 8;
  localparam int AW = 8;

  logic          clk = 1'b0;
  logic          rst_n, mode_active;
  logic [3:0]    config_max_dim;
  logic [EW-1:0] config_max_value;
  logic [7:0]    rx_data;
  logic          rx_done, clear_rx_buffer;
  logic [7:0]    tx_data;
  logic          tx_start, tx_busy;
  logic          alloc_req, alloc_valid, alloc_fail;
  logic [3:0]    alloc_slot;
  logic [AW-1:0] alloc_addr;
  logic          commit_req;
  logic [3:0]    commit_slot, commit_m, commit_n;
  logic [AW-1:0] commit_addr;
  logic          mem_wr_en;
  logic [AW-1:0] mem_wr_addr;
  logic [EW-1:0] mem_wr_data;
  logic [3:0]    error_code, sub_state;

  matrix_gen_batch #(.ELEMENT_WIDTH(EW), .ADDR_WIDTH(AW), .MAX_BATCH(4), .LFSR_SEED(16'hACE1)) dut (
    .clk(clk), .rst_n(rst_n), .mode_active(mode_active),
    .config_max_dim(config_max_dim), .config_max_value(config_max_value),
    .rx_data(rx_data), .rx_done(rx_done), .clear_rx_buffer(clear_rx_buffer),
    .tx_data(tx_data), .tx_start(tx_start), .tx_busy(tx_busy),
    .alloc_req(alloc_req), .alloc_slot(alloc_slot), .alloc_addr(alloc_addr),
    .alloc_valid(alloc_valid), .alloc_fail(alloc_fail),
    .commit_req(commit_req), .commit_slot(commit_slot), .commit_m(commit_m),
    .commit_n(commit_n), .commit_addr(commit_addr),
    .mem_wr_en(mem_wr_en), .mem_wr_addr(mem_wr_addr), .mem_wr_data(mem_wr_data),
    .error_code(error_code), .sub_state(sub_state)
  );

  always #5 clk = ~clk;

  typedef struct { logic [AW-1:0] addr; bit last_col; } wr_t;
  typedef struct { logic [3:0] slot; logic [3:0] m; logic [3:0] n; logic [AW-1:0] addr; } cm_t;

  wr_t   wq[$];
  cm_t   cq[$];
  byte   tq[$];
  string tx_log = "";

  int n_checks = 0, n_fail = 0;
  int tx_seen = 0, commits_seen = 0, allocs_seen = 0;
  int busy_len = 1, cur_m = 1, cur_n = 1, fail_mode = 0;
  bit abort_mode = 0, force_alloc = 0;
  logic [3:0]    f_slot = 4'd0;
  logic [AW-1:0] f_addr = '0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Scoreboard monitor plus UART busy model.
  initial begin : monitor
    logic [3:0] prev_sub;
    int         busy_cnt;
    wr_t        e;
    cm_t        c;
    byte        b;
    string      s;
    prev_sub = 4'd0;
    busy_cnt = 0;
    tx_busy  = 1'b0;
    forever begin
      @(negedge clk);
      if (rst_n) begin
        if (mem_wr_en) begin
          if (wq.size() == 0) chk("unexpected_write", {24'd0, mem_wr_addr}, 32'hFFFF_FFFF);
          else begin
            e = wq.pop_front();
            chk("wr_addr", {24'd0, mem_wr_addr}, {24'd0, e.addr});
            chk("wr_range", {31'd0, mem_wr_data <= config_max_value}, 32'd1);
            s = $sformatf("%0d", mem_wr_data);
            for (int i = 0; i < s.len(); i++) tq.push_back(s[i]);
            tq.push_back(e.last_col ? 8'h0A : 8'h20);
          end
        end
        if (tx_start) begin
          chk("tx_while_busy", {31'd0, tx_busy}, 32'd0);
          tx_seen++;
          tx_log = $sformatf("%s%c", tx_log, tx_data);
          if (tq.size() == 0) chk("unexpected_tx", {24'd0, tx_data}, 32'hFFFF_FFFF);
          else begin
            b = tq.pop_front();
            chk("tx_char", {24'd0, tx_data}, {24'd0, b});
          end
          busy_cnt = busy_len;
          tx_busy  = 1'b1;
        end else if (busy_cnt > 1) begin
          busy_cnt--;
        end else begin
          busy_cnt = 0;
          tx_busy  = 1'b0;
        end
        if (commit_req) begin
          commits_seen++;
          if (cq.size() == 0) chk("unexpected_commit", {28'd0, commit_slot}, 32'hFFFF_FFFF);
          else begin
            c = cq.pop_front();
            chk("commit_fields", {commit_slot, commit_m, commit_n, 12'd0, commit_addr},
                {c.slot, c.m, c.n, 12'd0, c.addr});
          end
        end
        if (prev_sub == 4'd11) chk("done_to_idle", {28'd0, sub_state}, 32'd0);
        prev_sub = sub_state;
      end
    end
  end

  // Allocator: answers each request after a random delay.
  initial begin : responder
    logic [3:0]    slot;
    logic [AW-1:0] addr;
    alloc_valid = 1'b0;
    alloc_fail  = 1'b0;
    alloc_slot  = 4'd0;
    alloc_addr  = '0;
    forever begin
      @(negedge clk);
      if (alloc_req) begin
        repeat ($urandom_range(0, 3)) @(negedge clk);
        if (alloc_req) begin
          allocs_seen++;
          slot = force_alloc ? f_slot : 4'($urandom_range(0, 15));
          addr = force_alloc ? f_addr : AW'($urandom);
          alloc_slot = slot;
          alloc_addr = addr;
          if (fail_mode == 1) alloc_fail = 1'b1;
          else begin
            alloc_valid = 1'b1;
            if (fail_mode == 2) alloc_fail = 1'b1;
            for (int i = 0; i < cur_m * cur_n; i++)
              wq.push_back('{addr: AW'(int'(addr) + i), last_col: ((i % cur_n) == cur_n - 1)});
            if (!abort_mode) cq.push_back('{slot: slot, m: 4'(cur_m), n: 4'(cur_n), addr: addr});
          end
          @(negedge clk);
          alloc_valid = 1'b0;
          alloc_fail  = 1'b0;
        end
      end
    end
  end

  task automatic send_byte(input logic [7:0] v);
    int t = 0;
    @(negedge clk);
    rx_data = v;
    rx_done = 1'b1;
    while (!clear_rx_buffer && t < 100) begin
      @(negedge clk);
      t++;
    end
    chk("rx_consumed", {31'd0, t < 100}, 32'd1);
    rx_done = 1'b0;
  endtask

  task automatic cmd(input int m, input int n, input int k);
    cur_m = m;
    cur_n = n;
    send_byte(8'(48 + m));
    send_byte(8'(48 + n));
    send_byte(8'(48 + k));
  endtask

  task automatic wait_done(input int target, input string name);
    int t = 0;
    while (!(commits_seen >= target && sub_state == 4'd1) && t < 20000) begin
      @(negedge clk);
      t++;
    end
    chk({name, "_timeout"}, {31'd0, t < 20000}, 32'd1);
    chk({name, "_left"}, wq.size() + tq.size() + cq.size(), 32'd0);
  endtask

  initial begin : stim
    int c0, t0, a0, t;
    rst_n = 1'b0;
    mode_active = 1'b1;
    config_max_dim = 4'd5;
    config_max_value = 8'd9;
    rx_data = 8'h00;
    rx_done = 1'b0;
    repeat (3) @(negedge clk);
    chk("rst_state", {28'd0, sub_state}, 32'd0);
    chk("rst_err", {28'd0, error_code}, {28'd0, `ERR_NONE});
    chk("rst_pulses", {27'd0, alloc_req, tx_start, mem_wr_en, commit_req, clear_rx_buffer}, 32'd0);
    chk("rst_data", {tx_data, mem_wr_addr, mem_wr_data, commit_addr}, 32'd0);
    chk("rst_commit", {20'd0, commit_slot, commit_m, commit_n}, 32'd0);
    rst_n = 1'b1;
    @(negedge clk);
    chk("idle_to_wait_m", {28'd0, sub_state}, 32'd1);
    send_byte("x");
    chk("nondigit_stay", {28'd0, sub_state}, 32'd1);

    // 2x3 single matrix at slot 2 / 0x40 with single-digit values
    force_alloc = 1; f_slot = 4'd2; f_addr = 8'h40;
    tx_log = "";
    cmd(2, 3, 1);
    wait_done(1, "basic");
    chk("basic_tx_len", tx_log.len(), 32'd12);
    force_alloc = 0;

    send_byte("6");
    chk("dim_err_code", {28'd0, error_code}, {28'd0, `ERR_DIM_RANGE});
    chk("dim_err_state", {28'd0, sub_state}, 32'd12);
    send_byte("a");
    chk("err_clear_code", {28'd0, error_code}, {28'd0, `ERR_NONE});
    chk("err_clear_state", {28'd0, sub_state}, 32'd1);
    send_byte("2"); send_byte("2"); send_byte("5");
    chk("k_range_err", {sub_state, error_code}, {28'd0, 4'd12, `ERR_DIM_RANGE});
    send_byte("q");

    a0 = allocs_seen;
    cmd(1, 1, 3);
    wait_done(commits_seen + 3, "batch3");
    chk("batch3_allocs", allocs_seen - a0, 32'd3);

    fail_mode = 2;
    cmd(1, 2, 1);
    wait_done(commits_seen + 1, "valid_wins");
    fail_mode = 0;

    config_max_value = 8'd0;
    tx_log = "";
    cmd(1, 1, 1);
    wait_done(commits_seen + 1, "zero1");
    chk("zero_tx", {31'd0, tx_log == "0\n"}, 32'd1);
    cmd(2, 2, 1);
    wait_done(commits_seen + 2 - 1, "zero2");

    config_max_value = 8'd200;
    config_max_dim = 4'd9;
    cmd(3, 3, 2);
    wait_done(commits_seen + 2, "big");
    force_alloc = 1; f_slot = 4'd7; f_addr = 8'hFE;
    cmd(2, 2, 1);
    wait_done(commits_seen + 1, "wrap");
    force_alloc = 0;

    for (int r = 0; r < 4; r++) begin
      config_max_dim = 4'($urandom_range(1, 6));
      config_max_value = 8'($urandom_range(5, 255));
      busy_len = $urandom_range(1, 4);
      t = $urandom_range(1, 2);
      cmd($urandom_range(1, int'(config_max_dim)), $urandom_range(1, int'(config_max_dim)), t);
      wait_done(commits_seen + t, "random");
    end
    busy_len = 1;

    // allocation failure
    fail_mode = 1;
    c0 = commits_seen;
    cmd(2, 2, 1);
    t = 0;
    while (sub_state != 4'd12 && t < 200) begin @(negedge clk); t++; end
    chk("alloc_fail_err", {sub_state, error_code}, {28'd0, 4'd12, `ERR_ALLOC_FAIL});
    repeat (20) @(negedge clk);
    chk("alloc_fail_nocommit", commits_seen - c0, 32'd0);
    fail_mode = 0;
    mode_active = 1'b0;
    @(negedge clk);
    chk("err_held_off", {sub_state, error_code}, {28'd0, 4'd0, `ERR_ALLOC_FAIL});
    mode_active = 1'b1;
    @(negedge clk);
    send_byte("0");
    chk("m_zero_err", {sub_state, error_code}, {28'd0, 4'd12, `ERR_DIM_RANGE});
    send_byte("z");
    chk("err_clear2", {sub_state, error_code}, {28'd0, 4'd1, `ERR_NONE});

    // long busy mid-row then disable mid-matrix
    config_max_dim = 4'd5;
    abort_mode = 1;
    busy_len = 50;
    t0 = tx_seen;
    cmd(2, 3, 1);
    t = 0;
    while (tx_seen == t0 && t < 3000) begin @(negedge clk); t++; end
    chk("abort_first_tx", {31'd0, tx_seen > t0}, 32'd1);
    repeat (20) @(negedge clk);
    mode_active = 1'b0;
    @(negedge clk);
    chk("abort_idle", {28'd0, sub_state}, 32'd0);
    chk("abort_pulses", {27'd0, alloc_req, tx_start, mem_wr_en, commit_req, clear_rx_buffer}, 32'd0);
    c0 = commits_seen;
    t0 = tx_seen;
    repeat (60) @(negedge clk);
    chk("abort_no_commit", commits_seen - c0, 32'd0);
    chk("abort_no_tx", tx_seen - t0, 32'd0);
    wq.delete();
    tq.delete();
    abort_mode = 0;
    busy_len = 1;
    mode_active = 1'b1;
    repeat (2) @(negedge clk);
    chk("reenable", {28'd0, sub_state}, 32'd1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/matrix_gen_batch.md
MATRIX_GEN_BATCH -- requirements
Module: matrix_gen_batch

Interface
REQ-001 Parameters (name, default, meaning) SHALL be:
 ELEMENT_WIDTH, `ELEMENT_WIDTH, stored element width (4..8);
 ADDR_WIDTH, `BRAM_ADDR_WIDTH, memory address width;
 MAX_BATCH, 4, max matrices generated per command (1..9);
 LFSR_SEED, 16'hACE1, non-zero LFSR reset value.
REQ-002 Ports (name, direction, width, meaning) SHALL be:
 clk, in, 1, single clock; reset is asynchronous and active-low;
 rst_n, in, 1, asynchronous active-low reset;
 mode_active, in, 1, block enabled;
 config_max_dim, in, 4, max legal m/n;
 config_max_value, in, ELEMENT_WIDTH, max element value, inclusive;
 rx_data, in, 8, received byte; rx_done, in, 1, byte valid;
 clear_rx_buffer, out, 1, consume received byte;
 tx_data, out, 8, byte to send; tx_start, out, 1, send pulse; tx_busy, in, 1, UART busy;
 alloc_req, out, 1; alloc_slot, in, 4; alloc_addr, in, ADDR_WIDTH; alloc_valid, in, 1; alloc_fail, in, 1, no free slot;
 commit_req, out, 1; commit_slot, out, 4; commit_m, out, 4; commit_n, out, 4; commit_addr, out, ADDR_WIDTH;
 mem_wr_en, out, 1; mem_wr_addr, out, ADDR_WIDTH; mem_wr_data, out, ELEMENT_WIDTH;
 error_code, out, 4, `ERR_NONE/`ERR_DIM_RANGE/`ERR_ALLOC_FAIL (new, in matrix_pkg.vh);
 sub_state, out, 4, current FSM state.

Function
REQ-003 States SHALL be IDLE=0, WAIT_M=1, WAIT_N=2, WAIT_K=3, ALLOC=4, DRAW=5, CONV=6, SEND_DIG=7, SEND_SEP=8, COMMIT=9, NEXT=10, DONE=11, ERROR=12; sub_state shows encoding.
REQ-004 IDLE SHALL go to WAIT_M next cycle when mode_active=1.
REQ-005 In WAIT_M/WAIT_N/WAIT_K, on rx_done with a non-digit byte: pulse clear_rx_buffer, stay.
REQ-006 Digit d for m or n: 1..config_max_dim accepted (latch, clear_rx_buffer, advance); else error_code=`ERR_DIM_RANGE, go ERROR.
REQ-007 Digit k in WAIT_K: 1..MAX_BATCH accepted (latch batch count, go ALLOC); else `ERR_DIM_RANGE, ERROR.
REQ-008 ALLOC SHALL hold alloc_req=1 until alloc_valid (latch slot/addr, reset element index, go DRAW) or alloc_fail (`ERR_ALLOC_FAIL, ERROR); alloc_valid wins if both high.
REQ-009 16-bit Galois LFSR (taps 16,14,13,11) SHALL advance every clock while mode_active, reset to LFSR_SEED, never zero.
REQ-010 DRAW: candidate = LFSR[ELEMENT_WIDTH-1:0]; if candidate > config_max_value, redraw next cycle (rejection sampling); else pulse mem_wr_en, mem_wr_addr=base+index, mem_wr_data=candidate, go CONV.
REQ-011 Elements SHALL be written row-major, index 0..m*n-1; address arithmetic ADDR_WIDTH bits, wrap modulo 2^ADDR_WIDTH.
REQ-012 CONV SHALL convert value to decimal digits by repeated subtraction of 100 then 10 (one subtraction per cycle), leading zeros suppressed; value 0 sends "0".
REQ-013 SEND_DIG/SEND_SEP SHALL raise tx_start for exactly one cycle only when tx_busy=0 and tx_start was 0 in the previous cycle; tx_data stable with the pulse.
REQ-014 Separator: space between elements of a row; 0x0A after last column; no trailing space.
REQ-015 After LF of final element: COMMIT pulses commit_req one cycle with slot/m/n/addr of the current matrix, then NEXT.
REQ-016 NEXT: if matrices done < batch count, go ALLOC; else DONE; DONE returns to IDLE next cycle.
REQ-017 ERROR: on rx_done, clear error_code to `ERR_NONE, pulse clear_rx_buffer, go WAIT_M.
REQ-018 mode_active=0 at any state: next cycle sub_state=IDLE, all pulse outputs 0, no commit for partial matrix; error_code held.

Reset
REQ-019 While rst_n=0: sub_state=IDLE; all pulse/request outputs 0; tx_data, mem_wr_addr, mem_wr_data, commit_* = 0; error_code=`ERR_NONE; LFSR=LFSR_SEED; counters 0.

Verification
REQ-020 max_dim=5, max_value=9, rx "2","3","1", alloc_valid slot 2 addr 0x40 -> 6 writes addr 0x40..0x45, TX "a b c\nd e f\n", one commit_req slot 2 m=2 n=3 addr 0x40.
REQ-021 rx "6" with max_dim=5 -> error_code=`ERR_DIM_RANGE, sub_state=12; next rx_done -> `ERR_NONE, WAIT_M.
REQ-022 k=3, m=n=1 -> three ALLOC handshakes, three commits, then DONE->IDLE.
REQ-023 max_value=0 -> every mem_wr_data=0, TX "0\n"; max_value=200, ELEMENT_WIDTH=8 -> all values <=200, multi-digit decimal correct.
REQ-024 alloc_fail in ALLOC -> `ERR_ALLOC_FAIL, no mem_wr_en, no commit.
REQ-025 tx_busy held high 50 cycles mid-row, then mode_active dropped mid-matrix -> no tx_start while busy, IDLE next cycle, no commit_req.
